// File: rtl/wb_arb_queue.sv
// wb_arb_queue: per-pipe result FIFOs merged onto one writeback channel.
// Each execute pipe owns a p_depth-entry FIFO. The non-squashed FIFO heads
// compete for the single writeback port. Squashes invalidate stored entries
// in place, and invalid heads are skipped at one entry per cycle.
// Build option: define WB_ARB_OLDEST_FIRST_EN to select oldest-first
// arbitration by age. When it is undefined, round-robin arbitration is used.
module wb_arb_queue #(
    parameter int p_num_pipes      = 4,
    parameter int p_depth          = 2,
    parameter int p_seq_num_bits   = 5,
    parameter int p_phys_addr_bits = 6
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [p_num_pipes-1:0]                   in_val,
    output logic [p_num_pipes-1:0]                   in_rdy,
    input  logic [p_num_pipes*p_seq_num_bits-1:0]    in_seq_num,
    input  logic [p_num_pipes*32-1:0]                in_pc,
    input  logic [p_num_pipes*p_phys_addr_bits-1:0]  in_waddr,
    input  logic [p_num_pipes*32-1:0]                in_wdata,
    input  logic [p_num_pipes-1:0]                   in_wen,
    output logic                                     out_val,
    input  logic                                     out_rdy,
    output logic [p_seq_num_bits-1:0]                out_seq_num,
    output logic [31:0]                              out_pc,
    output logic [p_phys_addr_bits-1:0]              out_waddr,
    output logic [31:0]                              out_wdata,
    output logic                                     out_wen,
    input  logic [p_seq_num_bits-1:0]                head_seq_num,
    input  logic                                     squash_val,
    input  logic [p_seq_num_bits-1:0]                squash_seq_num
);

    localparam int N  = p_num_pipes;
    localparam int S  = p_seq_num_bits;
    localparam int P  = p_phys_addr_bits;
    localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int CW = $clog2(p_depth) + 1;
    localparam int IW = $clog2(p_num_pipes);

    // Entry storage, indexed [pipe][slot]
    logic [S-1:0]   mem_seq   [N][p_depth];
    logic [31:0]    mem_pc    [N][p_depth];
    logic [P-1:0]   mem_waddr [N][p_depth];
    logic [31:0]    mem_wdata [N][p_depth];
    logic           mem_wen   [N][p_depth];
    logic           ent_valid [N][p_depth];

    logic [PW-1:0]  head_ptr [N];
    logic [PW-1:0]  tail_ptr [N];
    logic [CW-1:0]  count    [N];
    logic [IW-1:0]  rr_ptr;

    logic [S-1:0]   sq_age;
    logic [S-1:0]   head_seq [N];
    logic [N-1:0]   head_cand;
    logic [N-1:0]   head_skip;
    logic [N-1:0]   enq_keep;
    logic [N-1:0]   pop;
    logic           win_found;
    logic [IW-1:0]  win_idx;
    logic           deq;
`ifdef WB_ARB_OLDEST_FIRST_EN
    logic [S-1:0]   best_age;
`endif

    // Age relative to the oldest uncommitted instruction; smaller is older
    function automatic logic [S-1:0] age_of(input logic [S-1:0] seq,
                                            input logic [S-1:0] origin);
        return seq - origin;
    endfunction

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (int'(p) == p_depth - 1)
            return '0;
        return p + PW'(1);
    endfunction

    // Ready depends on stored occupancy only, never on this cycle's dequeue
    always_comb begin
        for (int i = 0; i < N; i++)
            in_rdy[i] = !rst && (count[i] != CW'(p_depth));
    end

    // Head status per pipe and squash filtering of incoming results
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        sq_age    = squash_seq_num - head_seq_num;
        head_cand = '0;
        head_skip = '0;
        enq_keep  = '0;
        for (int i = 0; i < N; i++) begin
            head_seq[i]  = mem_seq[i][head_ptr[i]];
            head_cand[i] = (count[i] != '0) && ent_valid[i][head_ptr[i]] &&
                           !(squash_val && (age_of(head_seq[i], head_seq_num) > sq_age));
            head_skip[i] = (count[i] != '0) && !ent_valid[i][head_ptr[i]];
            enq_keep[i]  = in_val[i] && in_rdy[i] &&
                           !(squash_val &&
                             (age_of(in_seq_num[i*S +: S], head_seq_num) > sq_age));
        end
    end

    // Writeback arbitration over the live heads
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
`ifdef WB_ARB_OLDEST_FIRST_EN
        best_age  = '1;
        for (int i = 0; i < N; i++) begin
            if (head_cand[i] &&
                (!win_found || (age_of(head_seq[i], head_seq_num) < best_age))) begin
                win_found = 1'b1;
                win_idx   = IW'(i);
                best_age  = age_of(head_seq[i], head_seq_num);
            end
        end
`else
        for (int k = 0; k < N; k++) begin
            if (!win_found && head_cand[(int'(rr_ptr) + k) % N]) begin
                win_found = 1'b1;
                win_idx   = IW'((int'(rr_ptr) + k) % N);
            end
        end
`endif
    end

    // Output mux and per-pipe pop decision
    always_comb begin
        out_val     = !rst && win_found;
        out_seq_num = mem_seq[win_idx][head_ptr[win_idx]];
        out_pc      = mem_pc[win_idx][head_ptr[win_idx]];
        out_waddr   = mem_waddr[win_idx][head_ptr[win_idx]];
        out_wdata   = mem_wdata[win_idx][head_ptr[win_idx]];
        out_wen     = mem_wen[win_idx][head_ptr[win_idx]];
        deq         = out_val && out_rdy;
        for (int i = 0; i < N; i++)
            pop[i] = (deq && (win_idx == IW'(i))) || head_skip[i];
    end

    // FIFO state: enqueue, dequeue/skip, squash invalidation, round-robin pointer
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
        if (rst) begin
            // NOTE: payload arrays are not reset; ent_valid and count alone decide what is live.
            for (int i = 0; i < N; i++) begin
                head_ptr[i] <= '0;
                tail_ptr[i] <= '0;
                count[i]    <= '0;
                for (int d = 0; d < p_depth; d++)
                    ent_valid[i][d] <= 1'b0;
            end
            rr_ptr <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int d = 0; d < p_depth; d++) begin
                    if (squash_val && (age_of(mem_seq[i][d], head_seq_num) > sq_age))
                        ent_valid[i][d] <= 1'b0;
                end
                if (pop[i]) begin
                    ent_valid[i][head_ptr[i]] <= 1'b0;
                    head_ptr[i]               <= ptr_next(head_ptr[i]);
                end
                if (enq_keep[i]) begin
                    mem_seq[i][tail_ptr[i]]   <= in_seq_num[i*S +: S];
                    mem_pc[i][tail_ptr[i]]    <= in_pc[i*32 +: 32];
                    mem_waddr[i][tail_ptr[i]] <= in_waddr[i*P +: P];
                    mem_wdata[i][tail_ptr[i]] <= in_wdata[i*32 +: 32];
                    mem_wen[i][tail_ptr[i]]   <= in_wen[i];
                    ent_valid[i][tail_ptr[i]] <= 1'b1;
                    tail_ptr[i]               <= ptr_next(tail_ptr[i]);
                end
                count[i] <= count[i] + CW'(enq_keep[i]) - CW'(pop[i]);
            end
            if (deq)
                rr_ptr <= (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
        end
    end

endmodule

// File: tb/tb_wb_arb_queue.sv
// tb_wb_arb_queue: directed bench for wb_arb_queue with a per-pipe scoreboard.
// Works with WB_ARB_OLDEST_FIRST_EN defined or undefined.
module tb_wb_arb_queue;

    localparam int N = 4;
    localparam int D = 2;
    localparam int S = 5;
    localparam int P = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     in_val;
    logic [N-1:0]     in_rdy;
    logic [N*S-1:0]   in_seq_num;
    logic [N*32-1:0]  in_pc;
    logic [N*P-1:0]   in_waddr;
    logic [N*32-1:0]  in_wdata;
    logic [N-1:0]     in_wen;
    logic             out_val;
    logic             out_rdy;
    logic [S-1:0]     out_seq_num;
    logic [31:0]      out_pc;
    logic [P-1:0]     out_waddr;
    logic [31:0]      out_wdata;
    logic             out_wen;
    logic [S-1:0]     head_seq_num;
    logic             squash_val;
    logic [S-1:0]     squash_seq_num;

    always #5 clk = ~clk;

    wb_arb_queue #(
        .p_num_pipes(N), .p_depth(D), .p_seq_num_bits(S), .p_phys_addr_bits(P)
    ) dut (
        .clk(clk), .rst(rst),
        .in_val(in_val), .in_rdy(in_rdy), .in_seq_num(in_seq_num),
        .in_pc(in_pc), .in_waddr(in_waddr), .in_wdata(in_wdata), .in_wen(in_wen),
        .out_val(out_val), .out_rdy(out_rdy), .out_seq_num(out_seq_num),
        .out_pc(out_pc), .out_waddr(out_waddr), .out_wdata(out_wdata), .out_wen(out_wen),
        .head_seq_num(head_seq_num), .squash_val(squash_val), .squash_seq_num(squash_seq_num)
    );

    typedef struct {
        logic [S-1:0] seq;
        logic [31:0]  pc;
        logic [P-1:0] waddr;
        logic [31:0]  wdata;
        logic         wen;
    } ent_t;

    ent_t         sb [N][$];
    logic [S-1:0] out_log [$];
    int           n_assert = 0;
    int           n_fail   = 0;
    int           deq_total = 0;
    int           deq_pipe [N];
    int           push_cnt [N];
    int           cyc;
    int           remaining;
    logic [S-1:0] exp_first, exp_second;

    function automatic logic [S-1:0] age(input logic [S-1:0] seq, input logic [S-1:0] hd);
        return seq - hd;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int p, input logic [S-1:0] seq, input logic [31:0] pc,
                          input logic [P-1:0] wa, input logic [31:0] wd, input logic we);
        in_val[p]            = 1'b1;
        in_seq_num[p*S +: S] = seq;
        in_pc[p*32 +: 32]    = pc;
        in_waddr[p*P +: P]   = wa;
        in_wdata[p*32 +: 32] = wd;
        in_wen[p]            = we;
    endtask

    task automatic clear_in();
        in_val = '0;
    endtask

    // One clock: sample handshakes on the falling edge, update the scoreboard,
    // then return just after the rising edge for the next stimulus step.
    task automatic tick();
        @(negedge clk);
        if (out_val && out_rdy) begin
            int hit;
            hit = -1;
            for (int i = 0; i < N; i++)
                if (hit < 0 && sb[i].size() > 0 && sb[i][0].seq === out_seq_num &&
                    sb[i][0].wdata === out_wdata)
                    hit = i;
            check("sb_match", 64'(hit >= 0), 64'd1);
            if (hit >= 0) begin
                check("sb_pc", 64'(out_pc), 64'(sb[hit][0].pc));
                check("sb_waddr", 64'(out_waddr), 64'(sb[hit][0].waddr));
                check("sb_wen", 64'(out_wen), 64'(sb[hit][0].wen));
                void'(sb[hit].pop_front());
                deq_pipe[hit]++;
            end
            deq_total++;
            out_log.push_back(out_seq_num);
        end
        if (squash_val) begin
            for (int i = 0; i < N; i++) begin
                ent_t keep [$];
                keep = {};
                for (int k = 0; k < sb[i].size(); k++)
                    if (!(age(sb[i][k].seq, head_seq_num) > age(squash_seq_num, head_seq_num)))
                        keep.push_back(sb[i][k]);
                sb[i] = keep;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (in_val[i] && in_rdy[i]) begin
                push_cnt[i]++;
                if (!(squash_val && age(in_seq_num[i*S +: S], head_seq_num) >
                                    age(squash_seq_num, head_seq_num))) begin
                    ent_t e;
                    e.seq   = in_seq_num[i*S +: S];
                    e.pc    = in_pc[i*32 +: 32];
                    e.waddr = in_waddr[i*P +: P];
                    e.wdata = in_wdata[i*32 +: 32];
                    e.wen   = in_wen[i];
                    sb[i].push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_val = '0; in_seq_num = '0; in_pc = '0; in_waddr = '0;
        in_wdata = '0; in_wen = '0; out_rdy = 1'b0; head_seq_num = '0;
        squash_val = 1'b0; squash_seq_num = '0;
        for (int i = 0; i < N; i++) begin deq_pipe[i] = 0; push_cnt[i] = 0; end

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_in_rdy", 64'(in_rdy), 64'h0);
        check("rst_out_val", 64'(out_val), 64'h0);
        rst = 1'b0;
        #1;
        check("post_rst_in_rdy", 64'(in_rdy), 64'hF);

        // Single result on pipe 2, one-cycle latency
        out_rdy = 1'b1;
        set_in(2, 5'd3, 32'h100, 6'd5, 32'hDEADBEEF, 1'b1);
        #1;
        check("t1_no_bypass", 64'(out_val), 64'h0);
        tick();
        clear_in();
        #1;
        check("t1_out_val", 64'(out_val), 64'h1);
        check("t1_seq", 64'(out_seq_num), 64'd3);
        check("t1_wdata", 64'(out_wdata), 64'hDEADBEEF);
        check("t1_waddr", 64'(out_waddr), 64'd5);
        check("t1_pc", 64'(out_pc), 64'h100);
        check("t1_wen", 64'(out_wen), 64'h1);
        tick();
        check("t1_empty", 64'(out_val), 64'h0);

        // Fill pipe 0 while stalled, then drain in order
        out_rdy = 1'b0;
        set_in(0, 5'd1, 32'h200, 6'd1, 32'hA1, 1'b1);
        tick();
        set_in(0, 5'd2, 32'h204, 6'd2, 32'hA2, 1'b0);
        tick();
        clear_in();
        #1;
        check("t2_full", 64'(in_rdy[0]), 64'h0);
        check("t2_head_seq", 64'(out_seq_num), 64'd1);
        out_rdy = 1'b1;
        #1;
        check("t2_no_rdy_bypass", 64'(in_rdy[0]), 64'h0);
        tick();
        check("t2_rdy_back", 64'(in_rdy[0]), 64'h1);
        check("t2_second_seq", 64'(out_seq_num), 64'd2);
        tick();
        check("t2_drained", 64'(out_val), 64'h0);

        // Wrap-around age with head at 30
`ifdef WB_ARB_OLDEST_FIRST_EN
        exp_first = 5'd31; exp_second = 5'd1;
`else
        exp_first = 5'd1;  exp_second = 5'd31;
`endif
        head_seq_num = 5'd30;
        out_rdy = 1'b0;
        set_in(1, 5'd1, 32'h300, 6'd11, 32'hB1, 1'b1);
        set_in(3, 5'd31, 32'h304, 6'd13, 32'hB3, 1'b1);
        tick();
        clear_in();
        #1;
        check("t3_first", 64'(out_seq_num), 64'(exp_first));
        out_rdy = 1'b1;
        tick();
        check("t3_second_val", 64'(out_val), 64'h1);
        check("t3_second", 64'(out_seq_num), 64'(exp_second));
        tick();
        check("t3_empty", 64'(out_val), 64'h0);

        // Squash at seq 5 with pipes holding 4..7 and a concurrent enqueue of 8
        head_seq_num = 5'd4;
        out_rdy = 1'b0;
        for (int i = 0; i < N; i++)
            set_in(i, 5'(4 + i), 32'h400 + 32'(i), 6'(20 + i), 32'hC0 + 32'(i), 1'b1);
        tick();
        clear_in();
        squash_val = 1'b1;
        squash_seq_num = 5'd5;
        set_in(0, 5'd8, 32'h408, 6'd28, 32'hC8, 1'b1);
        #1;
        check("t4_rdy_kept", 64'(in_rdy[0]), 64'h1);
        check("t4_out_val", 64'(out_val), 64'h1);
        check("t4_out_seq", 64'(out_seq_num), 64'd4);
        tick();
        squash_val = 1'b0;
        clear_in();
        out_log.delete();
        out_rdy = 1'b1;
        repeat (6) tick();
        check("t4_out_count", 64'(out_log.size()), 64'd2);
        if (out_log.size() >= 2) begin
            check("t4_out0", 64'(out_log[0]), 64'd4);
            check("t4_out1", 64'(out_log[1]), 64'd5);
        end
        check("t4_idle", 64'(out_val), 64'h0);
        check("t4_all_rdy", 64'(in_rdy), 64'hF);

        // A lone head squashed this cycle must not be offered
        out_rdy = 1'b0;
        set_in(3, 5'd7, 32'h500, 6'd30, 32'hD7, 1'b1);
        tick();
        clear_in();
        squash_val = 1'b1;
        squash_seq_num = 5'd5;
        #1;
        check("t4b_gated", 64'(out_val), 64'h0);
        tick();
        squash_val = 1'b0;
        out_rdy = 1'b1;
        out_log.delete();
        repeat (3) tick();
        check("t4b_no_out", 64'(out_log.size()), 64'd0);
        check("t4b_rdy", 64'(in_rdy), 64'hF);

        // Reset with three entries buffered
        head_seq_num = 5'd10;
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++)
            set_in(i, 5'(10 + i), 32'h600 + 32'(i), 6'(i), 32'hE0 + 32'(i), 1'b0);
        tick();
        clear_in();
        #1;
        check("t5_buffered", 64'(out_val), 64'h1);
        rst = 1'b1;
        #1;
        check("t5_rst_out_val", 64'(out_val), 64'h0);
        check("t5_rst_in_rdy", 64'(in_rdy), 64'h0);
        tick();
        for (int i = 0; i < N; i++) sb[i].delete();
        rst = 1'b0;
        #1;
        check("t5_post_rdy", 64'(in_rdy), 64'hF);
        check("t5_post_val", 64'(out_val), 64'h0);
        out_rdy = 1'b1;
        out_log.delete();
        repeat (3) tick();
        check("t5_no_stale", 64'(out_log.size()), 64'd0);

        // Continuous traffic on all pipes until 100 dequeues
        head_seq_num = '0;
        deq_total = 0;
        for (int i = 0; i < N; i++) begin deq_pipe[i] = 0; push_cnt[i] = 0; end
        cyc = 0;
        while (deq_total < 100 && cyc < 300) begin
            for (int i = 0; i < N; i++)
                set_in(i, 5'(push_cnt[i]), 32'h1000 + 32'(push_cnt[i]), 6'(i),
                       {4'(i), 28'(push_cnt[i])}, 1'b1);
            tick();
            cyc++;
        end
        out_rdy = 1'b0;
        clear_in();
        check("t6_deq_total", 64'(deq_total), 64'd100);
        check("t6_cycles", 64'(cyc), 64'd101);
`ifndef WB_ARB_OLDEST_FIRST_EN
        for (int i = 0; i < N; i++)
            check($sformatf("t6_share_pipe%0d", i), 64'(deq_pipe[i]), 64'd25);
`endif
        out_rdy = 1'b1;
        cyc = 0;
        remaining = sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size();
        while (remaining > 0 && cyc < 20) begin
            tick();
            cyc++;
            remaining = sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size();
        end
        check("t6_drain_left", 64'(remaining), 64'd0);
        check("t6_idle", 64'(out_val), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
